// File: rtl/neuron_layer_scheduler_pkg.sv
// Shared definitions for the neuron layer scheduler: FSM state encoding,
// watchdog margin and the result-slice addressing helper.
package neuron_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Extra RUN cycles allowed beyond NUM_INPUTS before a neuron is declared hung.
  localparam int WDOG_MARGIN = 8;

  // Base bit index of neuron idx inside the flat results vector.
  function automatic int slice_base(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/neuron_layer_scheduler_layer_result_buffer.sv
// Layer output buffer: one N-bit register per neuron, written by index,
// exposed as a flat vector with neuron i at bits [i*N +: N].
// Asynchronous active-low clear discards all stored results.
module layer_result_buffer
  import neuron_layer_scheduler_pkg::*;
#(
  parameter int N           = 8,
  parameter int NUM_NEURONS = 30,
  parameter int AW          = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [N-1:0]             wr_data_i,
  output logic [NUM_NEURONS*N-1:0] results_o
);

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_entry
    logic [N-1:0] entry_q;

    // Capture the write data when this entry is addressed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= '0;
      end else if (wr_en_i && (wr_addr_i == AW'(gi))) begin
        entry_q <= wr_data_i;
      end
    end

    assign results_o[slice_base(gi, N) +: N] = entry_q;
  end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Neuron layer scheduler: walks one shared neuron datapath across every
// neuron of a layer (restart, wait for ready, store result) and reports
// completion with a one-cycle done pulse.
// Optional watchdog: define NEURON_LAYER_SCHED_WATCHDOG_EN to abort a neuron
// that does not respond within NUM_INPUTS+WDOG_MARGIN RUN cycles.
module neuron_layer_scheduler
  import neuron_layer_scheduler_pkg::*;
#(
  parameter int N                 = 8,
  parameter int NUM_NEURONS       = 30,
  parameter int CLOG2_NUM_NEURONS = 5,
  parameter int NUM_INPUTS        = 62,
  parameter int CLOG2_WDOG        = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clk_en_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CLOG2_NUM_NEURONS-1:0]  neuron_sel_o,
  output logic                          neuron_rst_o,
  input  logic                          neuron_ready_i,
  input  logic signed [N-1:0]           neuron_result_i,
  output logic [NUM_NEURONS*N-1:0]      layer_results_o,
  output logic                          error_o
);

  localparam logic [CLOG2_NUM_NEURONS-1:0] LAST_SEL = CLOG2_NUM_NEURONS'(NUM_NEURONS - 1);

  // The watchdog counter must be able to reach its limit.
  if ((NUM_INPUTS + WDOG_MARGIN) >= (1 << CLOG2_WDOG)) begin : g_wdog_width_check
    $error("CLOG2_WDOG too small for NUM_INPUTS + WDOG_MARGIN");
  end

  state_e                         state_q, state_d;
  logic [CLOG2_NUM_NEURONS-1:0]   sel_q, sel_d;
  logic [N-1:0]                   hold_q, hold_d;
  logic                           store_req;

`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
  localparam logic [CLOG2_WDOG-1:0] WDOG_LAST = CLOG2_WDOG'(NUM_INPUTS + WDOG_MARGIN - 1);
  logic [CLOG2_WDOG-1:0]          wdog_q, wdog_d;
  logic                           error_q, error_d;

  // Watchdog count and sticky error advance only on enabled cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else if (clk_en_i) begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  // FSM state, neuron index and result holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      hold_q  <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: sequence CLEAR -> RUN -> STORE for each neuron, then DONE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    store_req = 1'b0;
`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
    wdog_d    = wdog_q;
    error_d   = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start_i) begin
          state_d = ST_CLEAR;
`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
          error_d = 1'b0;
`endif
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      ST_RUN: begin
        if (neuron_ready_i) begin
          hold_d  = neuron_result_i;
          state_d = ST_STORE;
        end
`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          // Hung neuron: record a zero result and move on.
          hold_d  = '0;
          error_d = 1'b1;
          state_d = ST_STORE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      ST_STORE: begin
        store_req = 1'b1;
        if (sel_q == LAST_SEL) begin
          state_d = ST_DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign neuron_rst_o = (state_q != ST_RUN);
  assign neuron_sel_o = sel_q;

  layer_result_buffer #(
    .N           (N),
    .NUM_NEURONS (NUM_NEURONS),
    .AW          (CLOG2_NUM_NEURONS)
  ) u_buffer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (store_req && clk_en_i),
    .wr_addr_i (sel_q),
    .wr_data_i (hold_q),
    .results_o (layer_results_o)
  );

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Testbench for neuron_layer_scheduler with a 3-neuron layer. A behavioural
// neuron raises ready K enabled cycles after its restart falls; expected done
// timing comes from counting enabled clock edges against NUM_NEURONS*(K+2).
module tb_neuron_layer_scheduler;

  localparam int N  = 8;
  localparam int NN = 3;
  localparam int SW = 2;
  localparam int NI = 62;
  localparam int WW = 7;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic               clk_en_i;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic [SW-1:0]      neuron_sel_o;
  logic               neuron_rst_o;
  logic               neuron_ready_i;
  logic signed [N-1:0] neuron_result_i;
  logic [NN*N-1:0]    layer_results_o;
  logic               error_o;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural neuron state
  int               model_k;
  int               model_cnt;
  int               dead_sel;
  logic             spur;
  logic [N-1:0]     res_table [NN];

  always #5 clk = ~clk;

  neuron_layer_scheduler #(
    .N(N), .NUM_NEURONS(NN), .CLOG2_NUM_NEURONS(SW), .NUM_INPUTS(NI), .CLOG2_WDOG(WW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .clk_en_i        (clk_en_i),
    .start_i         (start_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .neuron_sel_o    (neuron_sel_o),
    .neuron_rst_o    (neuron_rst_o),
    .neuron_ready_i  (neuron_ready_i),
    .neuron_result_i (neuron_result_i),
    .layer_results_o (layer_results_o),
    .error_o         (error_o)
  );

  // Neuron model: counts enabled cycles spent out of restart.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) model_cnt <= 0;
    else if (clk_en_i) model_cnt <= neuron_rst_o ? 0 : model_cnt + 1;
  end

  always_comb begin
    neuron_ready_i = spur ||
                     (!neuron_rst_o && (model_cnt == model_k - 1) && (int'(neuron_sel_o) != dead_sel));
    neuron_result_i = res_table[neuron_sel_o];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NN*N-1:0] pack_results();
    logic [NN*N-1:0] r;
    r = '0;
    for (int i = 0; i < NN; i++) r[i*N +: N] = res_table[i];
    return r;
  endfunction

  // Start a layer run and follow it to completion, checking done/busy each cycle.
  task automatic run_layer(input string tag, input int k, input int total_edges,
                           input int stall_at, input int stall_len, input int extra_start,
                           input bit start_at_done, input int spur_at, input bit rand_en,
                           input logic [NN*N-1:0] exp_res, input bit exp_err,
                           output int done_cyc);
    int en_cnt;
    en_cnt   = 0;
    done_cyc = -1;
    model_k  = k;
    clk_en_i = 1'b1;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    for (int cyc = 1; cyc <= total_edges + 400; cyc++) begin
      check($sformatf("%s done c%0d", tag, cyc), 64'(done_o), 64'(en_cnt == total_edges));
      check($sformatf("%s busy c%0d", tag, cyc), 64'(busy_o), 64'(en_cnt <= total_edges));
      if (done_o && done_cyc < 0) done_cyc = cyc;
      if (en_cnt > total_edges + 2) break;
      start_i  = (cyc == extra_start) || (start_at_done && en_cnt == total_edges);
      clk_en_i = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                 !(rand_en && $urandom_range(9) == 0);
      spur     = (cyc == spur_at);
      step();
      if (clk_en_i) en_cnt++;
      spur = 1'b0;
    end
    start_i  = 1'b0;
    clk_en_i = 1'b1;
    check({tag, " done seen"}, 64'(done_cyc >= 0), 64'd1);
    check({tag, " results"}, 64'(layer_results_o), 64'(exp_res));
    check({tag, " error"}, 64'(error_o), 64'(exp_err));
    $display("%s: k=%0d done at cycle %0d results=%h error=%0b",
             tag, k, done_cyc, layer_results_o, error_o);
  endtask

  typedef struct {
    int          k;
    int          stall_at;
    int          stall_len;
    int          extra_start;
    bit          start_at_done;
    int          spur_at;
    int          exp_done;
    logic [23:0] exp_res;
  } vec_t;

  vec_t vecs [4];
  int   dc;

  initial begin
    rst_ni = 1'b0; clk_en_i = 1'b1; start_i = 1'b0; spur = 1'b0;
    model_k = 5; dead_sel = -1;
    for (int i = 0; i < NN; i++) res_table[i] = N'(10 * (i + 1));

    vecs[0] = '{k: 5, stall_at: -1, stall_len: 0, extra_start: -1, start_at_done: 0, spur_at: -1, exp_done: 22, exp_res: 24'h1E140A};
    vecs[1] = '{k: 5, stall_at: -1, stall_len: 0, extra_start: 8,  start_at_done: 1, spur_at: -1, exp_done: 22, exp_res: 24'h1E140A};
    vecs[2] = '{k: 5, stall_at: 10, stall_len: 4, extra_start: -1, start_at_done: 0, spur_at: -1, exp_done: 26, exp_res: 24'h1E140A};
    vecs[3] = '{k: 5, stall_at: -1, stall_len: 0, extra_start: -1, start_at_done: 0, spur_at: 1,  exp_done: 22, exp_res: 24'h1E140A};

    // Reset state
    #12;
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst error", 64'(error_o), 64'd0);
    check("rst neuron_rst", 64'(neuron_rst_o), 64'd1);
    check("rst sel", 64'(neuron_sel_o), 64'd0);
    check("rst results", 64'(layer_results_o), 64'd0);
    rst_ni = 1'b1;
    step(); step();

    // Spurious ready while idle must not write the buffer
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    check("idle spur results", 64'(layer_results_o), 64'd0);
    check("idle spur busy", 64'(busy_o), 64'd0);
    $display("idle spurious ready: results=%h busy=%0b", layer_results_o, busy_o);

    // Directed table
    for (int v = 0; v < 4; v++) begin
      run_layer($sformatf("vec%0d", v), vecs[v].k, NN * (vecs[v].k + 2),
                vecs[v].stall_at, vecs[v].stall_len, vecs[v].extra_start,
                vecs[v].start_at_done, vecs[v].spur_at, 1'b0,
                vecs[v].exp_res, 1'b0, dc);
      check($sformatf("vec%0d done cycle", v), 64'(dc), 64'(vecs[v].exp_done));
    end

    // Reset in the middle of a run
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 12; c++) step();
    rst_ni = 1'b0;
    #1;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst results", 64'(layer_results_o), 64'd0);
    check("midrst neuron_rst", 64'(neuron_rst_o), 64'd1);
    check("midrst done", 64'(done_o), 64'd0);
    $display("mid-run reset: busy=%0b results=%h neuron_rst=%0b", busy_o, layer_results_o, neuron_rst_o);
    #3;
    rst_ni = 1'b1;
    step();
    run_layer("post-reset", 5, NN * 7, -1, 0, -1, 1'b0, -1, 1'b0, 24'h1E140A, 1'b0, dc);
    check("post-reset done cycle", 64'(dc), 64'd22);

    // Randomized runs: random latency, results, clock-enable gaps, stray starts
    for (int r = 0; r < 8; r++) begin
      int k;
      k = int'($urandom_range(6, 1));
      for (int i = 0; i < NN; i++) res_table[i] = N'($urandom_range(255));
      run_layer($sformatf("rand%0d", r), k, NN * (k + 2), -1, 0,
                int'($urandom_range(9, 2)), 1'($urandom_range(1)), -1, 1'b1,
                pack_results(), 1'b0, dc);
    end
    for (int i = 0; i < NN; i++) res_table[i] = N'(10 * (i + 1));

`ifdef NEURON_LAYER_SCHED_WATCHDOG_EN
    // Neuron 1 never answers: watchdog zeroes its entry and flags error
    dead_sel = 1;
    run_layer("wdog", 5, (NN - 1) * 7 + (NI + 8 + 2), -1, 0, -1, 1'b0, -1, 1'b0,
              24'h1E000A, 1'b1, dc);
    check("wdog done cycle", 64'(dc), 64'd87);
    dead_sel = -1;
    run_layer("wdog-clear", 5, NN * 7, -1, 0, -1, 1'b0, -1, 1'b0, 24'h1E140A, 1'b0, dc);
    check("wdog-clear done cycle", 64'(dc), 64'd22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
